// File: rtl/cv32e41p_sleep_unit_mc_pkg.sv
// Shared types and state encodings for the multi-channel sleep unit.
// Each channel FSM uses these so top and channel agree on the encoding.
package cv32e41p_sleep_unit_mc_pkg;

    typedef logic [2:0] sleep_state_e;

    localparam sleep_state_e SLEEP_OFF   = 3'd0;
    localparam sleep_state_e SLEEP_RUN   = 3'd1;
    localparam sleep_state_e SLEEP_DRAIN = 3'd2;
    localparam sleep_state_e SLEEP_GATED = 3'd3;
    localparam sleep_state_e SLEEP_WAKE  = 3'd4;

    // A channel is settled and usable only while it runs or drains.
    function automatic logic sleep_state_ready(input sleep_state_e s);
        return (s == SLEEP_RUN) || (s == SLEEP_DRAIN);
    endfunction

    // The clock is free-running in every state except OFF and GATED.
    function automatic logic sleep_state_clocked(input sleep_state_e s);
        return (s != SLEEP_OFF) && (s != SLEEP_GATED);
    endfunction

endpackage

// File: rtl/cv32e41p_clock_gate.sv
// Glitch-free latch-based clock gate with a scan override.
// The enable is captured while clk_i is low so clk_o never sees a runt pulse.
module cv32e41p_clock_gate (
    input  logic clk_i,
    input  logic en_i,
    input  logic scan_cg_en_i,
    output logic clk_o
);

    logic clk_en;

    // NOTE: this latch is intentional; it is transparent only while clk_i is low,
    // so an enable change can never cut or stretch a high phase of clk_o.
    always_latch begin
        if (!clk_i) begin
            clk_en = en_i | scan_cg_en_i;
        end
    end

    assign clk_o = clk_i & clk_en;

endmodule

// File: rtl/cv32e41p_sleep_ch.sv
// One sleep channel: idle-hysteresis / wake-settle FSM, counter and clock gate.
// All state is on the free-running clock; only clk_gated_o is gated.
module cv32e41p_sleep_ch
    import cv32e41p_sleep_unit_mc_pkg::*;
#(
    parameter int unsigned IDLE_CYCLES = 4,
    parameter int unsigned WAKE_CYCLES = 2,
    parameter int unsigned CNT_W       = 8
) (
    input  logic clk_ungated_i,
    input  logic rst_n,
    input  logic scan_cg_en_i,
    input  logic fetch_enable_i,
    input  logic busy_i,
    input  logic sleep_req_i,
    input  logic wake_i,
    input  logic no_sleep_i,
    output logic clk_gated_o,
    output logic sleep_o,
    output logic ready_o
);

    localparam logic [CNT_W-1:0] IDLE_LOAD = CNT_W'(IDLE_CYCLES);
    localparam logic [CNT_W-1:0] WAKE_LOAD = CNT_W'(WAKE_CYCLES);

    sleep_state_e     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_dec;
    logic             drain_abort;
    logic             en;

    assign cnt_dec     = (cnt_q != '0) ? cnt_q - CNT_W'(1) : '0;
    assign drain_abort = busy_i | ~sleep_req_i | no_sleep_i | wake_i;

    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned and infers a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            SLEEP_OFF: begin
                if (fetch_enable_i) state_d = SLEEP_RUN;
            end
            SLEEP_RUN: begin
                if (sleep_req_i && !busy_i && !no_sleep_i) begin
                    if (IDLE_CYCLES == 0) begin
                        state_d = SLEEP_GATED;
                        cnt_d   = '0;
                    end else begin
                        state_d = SLEEP_DRAIN;
                        cnt_d   = IDLE_LOAD;
                    end
                end
            end
            // Transitions fire as the count reaches zero, giving N+1 cycles of latency.
            SLEEP_DRAIN: begin
                if (drain_abort) begin
                    state_d = SLEEP_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_dec;
                    if (cnt_dec == '0) state_d = SLEEP_GATED;
                end
            end
            SLEEP_GATED: begin
                if (wake_i) begin
                    if (WAKE_CYCLES == 0) begin
                        state_d = SLEEP_RUN;
                    end else begin
                        state_d = SLEEP_WAKE;
                        cnt_d   = WAKE_LOAD;
                    end
                end
            end
            SLEEP_WAKE: begin
                cnt_d = cnt_dec;
                if (cnt_dec == '0) state_d = SLEEP_RUN;
            end
            default: begin
                state_d = SLEEP_OFF;
                cnt_d   = '0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk_ungated_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SLEEP_OFF;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // A wake opens the clock in the same cycle it is seen.
    assign en = fetch_enable_i &
                (sleep_state_clocked(state_q) | ((state_q == SLEEP_GATED) & wake_i));

    assign sleep_o = (state_q == SLEEP_GATED) & ~wake_i;
    assign ready_o = sleep_state_ready(state_q);

    cv32e41p_clock_gate u_clock_gate (
        .clk_i        (clk_ungated_i),
        .en_i         (en),
        .scan_cg_en_i (scan_cg_en_i),
        .clk_o        (clk_gated_o)
    );

    a_no_en_before_fetch : assert property (
        @(posedge clk_ungated_i) disable iff (!rst_n) !fetch_enable_i |-> !en);

    a_sleep_no_en : assert property (
        @(posedge clk_ungated_i) disable iff (!rst_n) sleep_o |-> !en);

    a_sleep_stable : assert property (
        @(posedge clk_ungated_i) disable iff (!rst_n)
        sleep_o |-> (state_d == state_q) && (cnt_d == cnt_q));

endmodule

// File: rtl/cv32e41p_sleep_unit_mc.sv
// Multi-channel sleep unit: sticky fetch enable, NUM_CH gated clock domains,
// and a core-level sleep indication once every domain is gated.
module cv32e41p_sleep_unit_mc
    import cv32e41p_sleep_unit_mc_pkg::*;
#(
    parameter int unsigned NUM_CH      = 2,
    parameter int unsigned IDLE_CYCLES = 4,
    parameter int unsigned WAKE_CYCLES = 2,
    parameter int unsigned CNT_W       = 8
) (
    input  logic              clk_ungated_i,
    input  logic              rst_n,
    input  logic              scan_cg_en_i,
    input  logic              fetch_enable_i,
    output logic              fetch_enable_o,
    input  logic [NUM_CH-1:0] ch_busy_i,
    input  logic [NUM_CH-1:0] ch_sleep_req_i,
    input  logic [NUM_CH-1:0] ch_wake_i,
    input  logic [NUM_CH-1:0] ch_no_sleep_i,
    output logic [NUM_CH-1:0] clk_gated_o,
    output logic [NUM_CH-1:0] ch_sleep_o,
    output logic [NUM_CH-1:0] ch_ready_o,
    output logic              core_sleep_o
);

    logic fetch_enable_q, fetch_enable_d;

    assign fetch_enable_d = fetch_enable_q | fetch_enable_i;

    always_ff @(posedge clk_ungated_i or negedge rst_n) begin
        if (!rst_n) begin
            fetch_enable_q <= 1'b0;
        end else begin
            fetch_enable_q <= fetch_enable_d;
        end
    end

    assign fetch_enable_o = fetch_enable_q;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        cv32e41p_sleep_ch #(
            .IDLE_CYCLES (IDLE_CYCLES),
            .WAKE_CYCLES (WAKE_CYCLES),
            .CNT_W       (CNT_W)
        ) u_ch (
            .clk_ungated_i  (clk_ungated_i),
            .rst_n          (rst_n),
            .scan_cg_en_i   (scan_cg_en_i),
            .fetch_enable_i (fetch_enable_q),
            .busy_i         (ch_busy_i[i]),
            .sleep_req_i    (ch_sleep_req_i[i]),
            .wake_i         (ch_wake_i[i]),
            .no_sleep_i     (ch_no_sleep_i[i]),
            .clk_gated_o    (clk_gated_o[i]),
            .sleep_o        (ch_sleep_o[i]),
            .ready_o        (ch_ready_o[i])
        );
    end

    // The parent may stop clk_ungated_i while this is high.
    assign core_sleep_o = fetch_enable_q & (&ch_sleep_o);

endmodule
